pool_window_ctrl: RTL and testbench
===================================

// Module: pool_window_ctrl
// PURPOSE
// - Sequencer between the conv-layer output stream and the max-pool datapath (2x2 window, stride 2).
// - Accepts a raster-scan feature map, buffers one row, and replays each 2x2 window as 4 beats.
// - Each beat drives pool_en, pool_first, pool_last and pool_data; collects q_en and flags frame completion.
// PARAMETERS
// - CH     6   channels per pixel; data word is `WD*CH bits (`WD from global.v)
// - IMG_W  28  input width in pixels; must be even
// - IMG_H  28  input height in pixels; must be even
// PORTS
// - clk         in   1          clock
// - rst_n       in   1          reset, asynchronous, active-low
// - start       in   1          pulse; arms one frame; ignored unless IDLE
// - in_valid    in   1          input pixel valid
// - in_ready    out  1          input pixel accepted when in_valid&in_ready
// - in_data     in   `WD*CH     input pixel, all channels
// - pool_en     out  1          to max-pool aa_en
// - pool_first  out  1          to max-pool aa_first_data
// - pool_last   out  1          to max-pool aa_last_data
// - pool_data   out  `WD*CH     to max-pool data_i
// - pool_q_en   in   1          max-pool q_en; one pulse per finished window
// - busy        out  1          high from start accept until frame_done
// - frame_done  out  1          1-cycle pulse when the last window result is seen
// - err         out  1          sticky protocol error; see CONFIGURATION
// BEHAVIOUR
// - Reset values: in_ready=0, pool_en/first/last=0, pool_data=0, busy=0, frame_done=0, err=0.
// - State: IDLE; all counters and buffers are cleared.
// - Counters: col 0..IMG_W-1, row 0..IMG_H-1, res_cnt 0..(IMG_W/2)*(IMG_H/2).
// - IDLE: in_ready=0. start -> RUN; col, row and res_cnt cleared.
// - RUN: in_ready=1.
//   - Accepted pixel, even row: written to rowbuf[col].
//   - Accepted pixel, odd row, even col: latched into hold.
//   - Accepted pixel, odd row, odd col: latched into cur; next state EMIT with beat=0.
//   - col wraps at IMG_W-1 and row increments.
// - EMIT: 4 consecutive cycles; in_ready=0; pool_en=1.
//   - Beat order on pool_data: rowbuf[col-1], rowbuf[col], hold, cur.
//   - pool_first=1 on beat 0 only; pool_last=1 on beat 3 only.
//   - After beat 3: last pixel of frame -> DRAIN, else -> RUN.
// - Latency: window-completing accept at cycle t gives beat 0 at t+1 and beat 3 at t+4.
//   Max-pool then answers with q_en at t+6.
// - Every window has pool_en low for >=2 cycles between windows, because 2 accepts are needed per window.
// - pool_data=0 whenever pool_en=0.
// - res_cnt increments on each pool_q_en while busy.
// - DRAIN: in_ready=0. When res_cnt reaches (IMG_W/2)*(IMG_H/2), the next cycle pulses frame_done, busy falls, state -> IDLE.
// - The final q_en may coincide with the DRAIN entry cycle; it must be counted and must not be lost.
// - start while busy is ignored.
// - in_valid outside RUN is not accepted; the data is held upstream.
// - rst_n low mid-frame: state -> IDLE immediately; partial windows are discarded; no frame_done.
// - rowbuf contents are don't-care after reset; they are never read before being rewritten.
// CONFIGURATION
// - Macro POOL_CTRL_ERR_EN.
// - Defined: err sets and stays set until reset on any of these:
//   - pool_q_en while not busy;
//   - pool_q_en when res_cnt already equals (IMG_W/2)*(IMG_H/2);
//   - start asserted while busy.
// - Not defined: err tied 0; no check logic is synthesised; the other behaviour is identical.
// TESTING
// - IMG_W=4, IMG_H=4, CH=1, pixel value = 16*row+col, in_valid always high.
//   -> 4 windows with beats (0,1,16,17), (2,3,18,19), (32,33,48,49), (34,35,50,51).
//   -> first/last flags on beats 0/3; frame_done one cycle after the 4th pool_q_en.
// - Same frame, in_valid toggled 1-0-1-0.
//   -> identical beat sequence; in_ready=0 during every EMIT; no pixel dropped or duplicated.
// - Window-completing accept at cycle 10 -> pool_first at cycle 11, pool_last at 14.
//   -> model q_en at 16; res_cnt=1 at 17.
// - rst_n pulsed low while in EMIT beat 2 -> all outputs 0 next edge; then start and a full frame.
//   -> correct 4 windows; no stale beats.
// - With POOL_CTRL_ERR_EN: pool_q_en injected in IDLE -> err=1 and held.
//   Without the macro: err stays 0.
// - start re-pulsed mid-frame -> ignored; frame completes normally.
//   -> err=1 only with POOL_CTRL_ERR_EN.

Source files
------------

// File: rtl/pool_window_ctrl.sv
// 2x2/stride-2 max-pool window sequencer: buffers one input row and replays each window as 4 beats.
// Optional sticky protocol-error flag is built only when POOL_CTRL_ERR_EN is defined.
`ifndef WD
`define WD 8
`endif

module pool_window_ctrl #(
   parameter int CH    = 6,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [`WD*CH-1:0]    in_data,
   output logic                 pool_en,
   output logic                 pool_first,
   output logic                 pool_last,
   output logic [`WD*CH-1:0]    pool_data,
   input  logic                 pool_q_en,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 err
);

   localparam int DW    = `WD*CH;
   localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int TOTAL = (IMG_W/2)*(IMG_H/2);
   localparam int NW    = $clog2(TOTAL+1);

   typedef enum logic [1:0] {IDLE, RUN, EMIT, DRAIN} state_t;
   state_t state, state_nx;

   logic [CW-1:0] col, wcol;
   logic [RW-1:0] row;
   logic [NW-1:0] res_cnt;
   logic [1:0]    beat;
   logic          last_win;
   logic [DW-1:0] hold, cur;
   logic [DW-1:0] rowbuf [IMG_W];

   logic col_end, row_end, res_full, acc;
   assign col_end  = (col == CW'(IMG_W-1));
   assign row_end  = (row == RW'(IMG_H-1));
   assign res_full = (res_cnt == NW'(TOTAL));
   assign acc      = (state == RUN) && in_valid;

   always_comb begin
      state_nx   = state;
      in_ready   = 1'b0;
      pool_en    = 1'b0;
      pool_first = 1'b0;
      pool_last  = 1'b0;
      pool_data  = '0;
      frame_done = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE:  if (start) state_nx = RUN;
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && row[0] && col[0]) state_nx = EMIT;
         end
         EMIT: begin
            pool_en    = 1'b1;
            pool_first = (beat == 2'd0);
            pool_last  = (beat == 2'd3);
            case (beat)
               2'd0:    pool_data = rowbuf[wcol - CW'(1)];
               2'd1:    pool_data = rowbuf[wcol];
               2'd2:    pool_data = hold;
               default: pool_data = cur;
            endcase
            if (beat == 2'd3) state_nx = last_win ? DRAIN : RUN;
         end
         DRAIN: begin
            // res_cnt is registered, so the pulse lands the cycle after the last q_en
            if (res_full) begin
               frame_done = 1'b1;
               state_nx   = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         col      <= '0;
         row      <= '0;
         wcol     <= '0;
         res_cnt  <= '0;
         beat     <= '0;
         last_win <= 1'b0;
         hold     <= '0;
         cur      <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               col <= '0;
               row <= '0;
            end
            RUN: if (in_valid) begin
               if (row[0] && !col[0]) hold <= in_data;
               if (row[0] && col[0]) begin
                  cur      <= in_data;
                  wcol     <= col;
                  last_win <= row_end && col_end;
                  beat     <= '0;
               end
               if (col_end) begin
                  col <= '0;
                  row <= row_end ? '0 : row + RW'(1);
               end else begin
                  col <= col + CW'(1);
               end
            end
            EMIT:    beat <= beat + 2'd1;
            default: ;
         endcase
         // counted in any busy state so a q_en landing on DRAIN entry is kept
         if (state == IDLE && start) res_cnt <= '0;
         else if (pool_q_en && busy && !res_full) res_cnt <= res_cnt + NW'(1);
      end
   end

   // Even rows only; contents are always rewritten before the odd row reads them.
   always_ff @(posedge clk) begin
      if (acc && !row[0]) rowbuf[col] <= in_data;
   end

`ifdef POOL_CTRL_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else if ((pool_q_en && (!busy || res_full)) || (start && busy)) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Bench for pool_window_ctrl at 4x4x1: window beats, flags, latency, stalls, reset, err flag.
`ifndef WD
`define WD 8
`endif

module tb_pool_window_ctrl;
   localparam int W = 4, H = 4, DW = `WD;
   localparam int NPIX = W*H, NWIN = (W/2)*(H/2);
`ifdef POOL_CTRL_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_ready;
   logic [DW-1:0] in_data = '0, pool_data;
   logic pool_en, pool_first, pool_last, pool_q_en, busy, frame_done, err;

   pool_window_ctrl #(.CH(1), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .pool_en(pool_en), .pool_first(pool_first), .pool_last(pool_last),
      .pool_data(pool_data), .pool_q_en(pool_q_en), .busy(busy), .frame_done(frame_done), .err(err));

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0, viol = 0;
   int acc_cyc[$], first_cyc[$], last_cyc[$], q_cyc[$], fd_cyc[$];
   logic [DW-1:0] beat_d[$];
   logic beat_f[$], beat_l[$];
   logic [1:0] lastsh = '0;
   logic inj_q = 0;
   logic [DW-1:0] img [NPIX];

   // Observer plus max-pool stand-in: q_en two cycles after each pool_last.
   initial begin
      pool_q_en = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) lastsh = '0;
         pool_q_en = lastsh[1] | inj_q;
         inj_q = 0;
         lastsh = {lastsh[0], pool_last};
         if (pool_q_en) q_cyc.push_back(cyc);
         if (in_valid && in_ready) acc_cyc.push_back(cyc);
         if (pool_en) begin
            beat_d.push_back(pool_data); beat_f.push_back(pool_first); beat_l.push_back(pool_last);
         end
         if (pool_first) first_cyc.push_back(cyc);
         if (pool_last) last_cyc.push_back(cyc);
         if (pool_en && in_ready) viol++;
         if (!pool_en && (pool_data != 0 || pool_first || pool_last)) viol++;
         if (frame_done) fd_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      acc_cyc.delete(); first_cyc.delete(); last_cyc.delete(); q_cyc.delete(); fd_cyc.delete();
      beat_d.delete(); beat_f.delete(); beat_l.delete(); viol = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_pool_en"}, pool_en, 0);
      chk({tag, "_first_last"}, {pool_first, pool_last}, 0);
      chk({tag, "_pool_data"}, pool_data, 0);
      chk({tag, "_busy_done"}, {busy, frame_done}, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // mode 0: valid always, 1: valid toggles, 2: random valid. Image filled beforehand.
   task automatic run_frame(input string tag, input int mode, input bit restart, input logic exp_err);
      int p = 0, g = 0, wr, wc, idx;
      logic a;
      logic [DW-1:0] ew [4];
      clear_obs();
      while (p < NPIX && g < 2000) begin
         start    = (g == 0) || (restart && g == 12);
         in_data  = img[p];
         in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         a = in_valid && in_ready;
         @(posedge clk); #1;
         if (a) p++;
         g++;
      end
      start = 0; in_valid = 0;
      chk({tag, "_all_pixels_taken"}, p, NPIX);
      for (int k = 0; k < 100 && fd_cyc.size() == 0; k++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_beat_count"}, beat_d.size(), 4*NWIN);
      chk({tag, "_done_count"}, fd_cyc.size(), 1);
      chk({tag, "_q_count"}, q_cyc.size(), NWIN);
      chk({tag, "_protocol_viol"}, viol, 0);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_err"}, err, exp_err);
      if (fd_cyc.size() == 1 && q_cyc.size() == NWIN)
         chk({tag, "_done_after_last_q"}, fd_cyc[0], q_cyc[NWIN-1] + 1);
      for (int w = 0; w < NWIN; w++) begin
         wr = w / (W/2); wc = w % (W/2);
         ew[0] = img[2*wr*W + 2*wc];     ew[1] = img[2*wr*W + 2*wc + 1];
         ew[2] = img[(2*wr+1)*W + 2*wc]; ew[3] = img[(2*wr+1)*W + 2*wc + 1];
         for (int b = 0; b < 4; b++) if (4*w + b < beat_d.size()) begin
            chk($sformatf("%s_w%0d_b%0d_data", tag, w, b), beat_d[4*w+b], ew[b]);
            chk($sformatf("%s_w%0d_b%0d_flags", tag, w, b), {beat_f[4*w+b], beat_l[4*w+b]},
                {b == 0, b == 3});
         end
         idx = (2*wr+1)*W + 2*wc + 1;
         if (idx < acc_cyc.size() && w < first_cyc.size() && w < last_cyc.size() && w < q_cyc.size()) begin
            chk($sformatf("%s_w%0d_first_lat", tag, w), first_cyc[w], acc_cyc[idx] + 1);
            chk($sformatf("%s_w%0d_last_lat", tag, w), last_cyc[w], acc_cyc[idx] + 4);
            chk($sformatf("%s_w%0d_q_lat", tag, w), q_cyc[w], acc_cyc[idx] + 6);
         end else begin
            chk($sformatf("%s_w%0d_timing_present", tag, w), 0, 1);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 0; start = 0; in_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      bit seen;
      int g;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1;
      @(posedge clk); #1;

      for (int i = 0; i < NPIX; i++) img[i] = DW'(16*(i/W) + (i%W));
      run_frame("seq_valid", 0, 0, 1'b0);
      run_frame("toggle_valid", 1, 0, 1'b0);
      for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom_range(0, 255));
      run_frame("rand_valid", 2, 0, 1'b0);

      // reset asserted during beat 2 of the first window
      for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom_range(0, 255));
      start = 1; in_valid = 1;
      begin
         int p = 0;
         seen = 0; g = 0;
         while (!seen && g < 200) begin
            in_data = img[p];
            @(negedge clk);
            seen = pool_first;
            if (in_valid && in_ready) p++;
            @(posedge clk); #1;
            start = 0; g++;
         end
      end
      chk("rst_mid_first_seen", seen, 1);
      @(posedge clk); #1;
      rst_n = 0; in_valid = 0;
      #1 check_outputs_zero("rst_mid_async");
      @(negedge clk);
      check_outputs_zero("rst_mid_edge");
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom_range(0, 255));
      run_frame("after_rst", 2, 0, 1'b0);

      // stray q_en while idle
      inj_q = 1;
      repeat (2) @(posedge clk);
      #1 chk("idle_q_err", err, EXP_ERR);
      repeat (5) @(posedge clk);
      #1 chk("idle_q_err_held", err, EXP_ERR);
      chk("idle_q_busy", busy, 0);
      do_reset();
      chk("err_cleared", err, 0);

      // start re-pulsed mid-frame
      for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom_range(0, 255));
      run_frame("restart", 2, 1, EXP_ERR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
